// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - micro-op sequencer that feeds one pe compute unit
// Runs one job at a time: flush, stream MAC terms, optional bias and ReLU, emit, return result.
module pe_seq_ctrl #(
  parameter int LEN_W = 16,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_bias_en,
  input  logic             cfg_relu_en,
  input  logic [XLEN-1:0]  cfg_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [XLEN-1:0]  op_x,
  input  logic [XLEN-1:0]  op_w,
  input  logic             abort,
  output logic [XLEN-1:0]  pe_x,
  output logic [XLEN-1:0]  pe_weight,
  output logic             pe_in_valid,
  output logic             pe_flush,
  output logic             pe_out_en,
  output logic             pe_calc_bias,
  output logic             pe_calc_relu,
  input  logic [XLEN-1:0]  pe_result,
  input  logic             pe_out_valid,
  input  logic             pe_illegal_uop,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_MAC, S_BIAS, S_RELU, S_EMIT, S_OUT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic             bias_en;
  logic             relu_en;
  logic [XLEN-1:0]  bias;
  logic             aborting;

  // Abort only matters while the PE holds partial state; IDLE and OUT ignore it.
  assign aborting = abort && (state inside {S_FLUSH, S_MAC, S_BIAS, S_RELU, S_EMIT});

  function automatic state_t post_mac(input logic b, input logic r);
    return b ? S_BIAS : (r ? S_RELU : S_EMIT);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bias_en <= 1'b0;
      relu_en <= 1'b0;
      bias    <= '0;
      err     <= 1'b0;
    end else begin
      if (aborting) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (cfg_valid) begin
            cnt     <= cfg_len;
            bias_en <= cfg_bias_en;
            relu_en <= cfg_relu_en;
            bias    <= cfg_bias;
            err     <= 1'b0;
            state   <= S_FLUSH;
          end
          S_FLUSH: state <= (cnt != '0) ? S_MAC : post_mac(bias_en, relu_en);
          S_MAC: if (op_valid) begin
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state <= post_mac(bias_en, relu_en);
          end
          S_BIAS:  state <= relu_en ? S_RELU : S_EMIT;
          S_RELU:  state <= S_EMIT;
          S_EMIT:  state <= S_OUT;
          S_OUT:   if (pe_out_valid && res_ready) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      // Placed last so an illegal flag in the accept cycle is not lost.
      if (pe_illegal_uop) err <= 1'b1;
    end
  end

  always_comb begin
    cfg_ready    = 1'b0;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    pe_x         = '0;
    pe_weight    = '0;
    pe_in_valid  = 1'b0;
    pe_flush     = 1'b0;
    pe_out_en    = 1'b0;
    pe_calc_bias = 1'b0;
    pe_calc_relu = 1'b0;
    case (state)
      S_IDLE:  cfg_ready = 1'b1;
      S_FLUSH: pe_flush = 1'b1;
      S_MAC: begin
        op_ready    = 1'b1;
        pe_in_valid = op_valid;
        pe_x        = op_valid ? op_x : '0;
        pe_weight   = op_valid ? op_w : '0;
      end
      S_BIAS: begin
        pe_in_valid  = 1'b1;
        pe_calc_bias = 1'b1;
        pe_weight    = bias;
      end
      S_RELU:  pe_calc_relu = 1'b1;
      S_EMIT:  pe_out_en = 1'b1;
      S_OUT:   res_valid = pe_out_valid;
      default: cfg_ready = 1'b0;
    endcase
    if (aborting) begin
      op_ready    = 1'b0;
      pe_x        = '0;
      pe_weight   = '0;
      pe_in_valid = 1'b0;
      pe_flush    = 1'b1;
      pe_out_en   = 1'b0;
      pe_calc_bias = 1'b0;
      pe_calc_relu = 1'b0;
    end
  end

  assign res_data = pe_result;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb/tb_pe_seq_ctrl.sv - self-checking bench for pe_seq_ctrl with a behavioural pe
// Job results and latencies come from plain arithmetic over the job descriptor.
module tb_pe_seq_ctrl;
  localparam int XLEN  = 32;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cfg_valid = 0, cfg_ready, cfg_bias_en = 0, cfg_relu_en = 0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [XLEN-1:0]  cfg_bias = '0, op_x = '0, op_w = '0;
  logic             op_valid = 0, op_ready, abort = 0;
  logic [XLEN-1:0]  pe_x, pe_weight, pe_result, res_data;
  logic pe_in_valid, pe_flush, pe_out_en, pe_calc_bias, pe_calc_relu;
  logic pe_out_valid, pe_illegal_uop, res_valid, busy, err;
  logic res_ready = 0, force_illegal = 0;

  pe_seq_ctrl #(.LEN_W(LEN_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_len(cfg_len), .cfg_bias_en(cfg_bias_en), .cfg_relu_en(cfg_relu_en),
    .cfg_bias(cfg_bias), .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x),
    .op_w(op_w), .abort(abort), .pe_x(pe_x), .pe_weight(pe_weight),
    .pe_in_valid(pe_in_valid), .pe_flush(pe_flush), .pe_out_en(pe_out_en),
    .pe_calc_bias(pe_calc_bias), .pe_calc_relu(pe_calc_relu),
    .pe_result(pe_result), .pe_out_valid(pe_out_valid),
    .pe_illegal_uop(pe_illegal_uop), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .busy(busy), .err(err)
  );

  // Behavioural PE: accumulator with bias, ReLU and a registered result.
  logic [XLEN-1:0] acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0; pe_result <= '0; pe_out_valid <= 1'b0;
    end else if (pe_flush) begin
      acc <= '0; pe_out_valid <= 1'b0;
    end else if (pe_in_valid && pe_calc_bias) acc <= acc + pe_weight;
    else if (pe_in_valid)                      acc <= acc + pe_x * pe_weight;
    else if (pe_calc_relu)                     acc <= acc[XLEN-1] ? '0 : acc;
    else if (pe_out_en) begin
      pe_result <= acc; pe_out_valid <= 1'b1;
    end
  end
  assign pe_illegal_uop = force_illegal
    || ((int'(pe_flush) + int'(pe_out_en) + int'(pe_calc_bias) + int'(pe_calc_relu)) > 1)
    || (pe_calc_bias && !pe_in_valid) || (pe_calc_relu && pe_in_valid)
    || (pe_in_valid && (pe_flush || pe_out_en));

  int checks = 0, passed = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

  // Job descriptor and expectation shared with the compare process.
  int              j_k, j_rdelay, j_abort_at, j_stall[8], exp_lat = -1, acc_cyc = 0, last_lat = 0;
  logic            j_b, j_r, exp_err = 0, prev_rv = 0;
  logic [XLEN-1:0] j_bias, j_x[8], j_w[8], exp_res = 0, prev_data = 0, last_data = 0;

  function automatic logic [XLEN-1:0] model_res();
    logic [XLEN-1:0] s = '0;
    for (int i = 0; i < j_k; i++) s = s + j_x[i] * j_w[i];
    if (j_b) s = s + j_bias;
    if (j_r && $signed(s) < 0) s = '0;
    return s;
  endfunction

  function automatic int model_lat();
    int n = j_k + int'(j_b) + int'(j_r) + 3;
    for (int i = 0; i < j_k; i++) n += j_stall[i];
    return n;
  endfunction

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        prev_rv = 0; exp_err = 0;
        continue;
      end
      chk("cfg_ready_vs_busy", cfg_ready, !busy);
      chk("err_flag", err, exp_err);
      if (op_ready && !op_valid)
        chk("gap_uop_zero", {pe_in_valid, pe_flush, pe_out_en, pe_calc_bias, pe_calc_relu,
                             |pe_x, |pe_weight}, '0);
      if (!op_ready && !pe_calc_bias) chk("xw_zero", pe_x | pe_weight, '0);
      if (res_valid) chk("cfg_ready_in_out", cfg_ready, 0);
      if (res_valid && !prev_rv) begin
        last_lat  = cyc - acc_cyc;
        last_data = res_data;
        chk("res_expected", exp_lat >= 0, 1);
        if (exp_lat >= 0) begin
          chk("res_latency", last_lat, exp_lat);
          chk("res_data", res_data, exp_res);
        end
      end else if (res_valid && prev_rv) chk("res_stable", res_data, prev_data);
      prev_rv   = res_valid && !res_ready;
      prev_data = res_data;
      if (cfg_valid && cfg_ready) begin acc_cyc = cyc; exp_err = 0; end
      if (force_illegal) exp_err = 1;
    end
  end

  task automatic set_job(input int k, input logic b, input logic r, input logic [XLEN-1:0] bv,
                         input int rd, input int ab);
    j_k = k; j_b = b; j_r = r; j_bias = bv; j_rdelay = rd; j_abort_at = ab;
    for (int i = 0; i < 8; i++) j_stall[i] = 0;
  endtask

  task automatic run_job();
    int g, st;
    bit sent;
    exp_res = model_res();
    exp_lat = (j_abort_at >= 0) ? -1 : model_lat();
    @(negedge clk); #1;
    res_ready = 0;
    cfg_valid = 1; cfg_len = LEN_W'(j_k); cfg_bias_en = j_b; cfg_relu_en = j_r; cfg_bias = j_bias;
    chk("cfg_ready_at_start", cfg_ready, 1);
    g = 0;
    while (!cfg_ready) begin
      if (++g > 50) timeout("cfg_accept");
      @(negedge clk); #1;
    end
    for (int i = 0; i < j_k; i++) begin
      st = j_stall[i]; sent = 0; g = 0;
      while (!sent) begin
        @(negedge clk); #1;
        cfg_valid = 0;
        if (++g > 50) timeout("op_accept");
        if (!op_ready) begin op_valid = 0; continue; end
        if (st > 0) begin op_valid = 0; st--; continue; end
        op_valid = 1; op_x = j_x[i]; op_w = j_w[i];
        if (i == j_abort_at) begin
          abort = 1; #1;
          chk("abort_flush", pe_flush, 1);
          chk("abort_op_ready", op_ready, 0);
          chk("abort_in_valid", pe_in_valid, 0);
          @(negedge clk); #1;
          abort = 0; op_valid = 0;
          chk("abort_to_idle", busy, 0);
          return;
        end
        sent = 1;
      end
    end
    @(negedge clk); #1;
    op_valid = 0; cfg_valid = 0;
    g = 0;
    while (!res_valid) begin
      if (++g > 100) timeout("res_valid");
      @(negedge clk); #1;
    end
    repeat (j_rdelay) begin @(negedge clk); #1; end
    res_ready = 1;
    #3;
  endtask

  task automatic fill_ops(input logic [XLEN-1:0] x0, x1, x2, w0, w1, w2);
    j_x[0] = x0; j_x[1] = x1; j_x[2] = x2; j_w[0] = w0; j_w[1] = w1; j_w[2] = w2;
  endtask

  initial begin
    #1000000;
    timeout("watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_outputs", {op_ready, res_valid, busy, err}, '0);
    chk("rst_pe_ctrl", {pe_in_valid, pe_flush, pe_out_en, pe_calc_bias, pe_calc_relu}, '0);
    chk("rst_pe_xw", pe_x | pe_weight, '0);
    rst_n = 1;

    // Accumulate, bias, ReLU: 4+10+18-40 = -8 -> ReLU -> 0 at cycle 8.
    fill_ops(1, 2, 3, 4, 5, 6);
    set_job(3, 1, 1, -40, 0, -1); run_job();
    chk("t1_data", last_data, 0);  chk("t1_lat", last_lat, 8);
    set_job(3, 1, 0, -40, 0, -1); run_job();
    chk("t2_data", last_data, 32'hFFFF_FFF8); chk("t2_lat", last_lat, 7);
    set_job(3, 1, 1, -40, 0, -1); j_stall[1] = 2; j_stall[2] = 2; run_job();
    chk("t3_data", last_data, 0);  chk("t3_lat", last_lat, 12);
    set_job(0, 1, 0, 7, 0, -1); run_job();
    chk("t4_data", last_data, 7);
    set_job(0, 0, 0, 7, 0, -1); run_job();
    chk("t5_data", last_data, 0);  chk("t5_lat", last_lat, 3);

    // Back-pressure, then a job accepted the cycle after the handshake.
    set_job(3, 1, 1, -40, 5, -1); run_job();
    chk("bp_data", last_data, 0);
    set_job(3, 1, 0, -40, 0, -1); run_job();
    chk("bp_next_data", last_data, 32'hFFFF_FFF8);

    set_job(3, 1, 1, -40, 0, 1); run_job();
    j_x[0] = 2; j_w[0] = 3;
    set_job(1, 0, 0, 0, 0, -1); run_job();
    chk("after_abort_data", last_data, 6); chk("after_abort_lat", last_lat, 4);

    // Sticky error flag, cleared by the next accept.
    @(negedge clk); #1; res_ready = 0; force_illegal = 1;
    @(negedge clk); #1; force_illegal = 0;
    repeat (2) @(negedge clk);
    #1; chk("err_sticky", err, 1);
    fill_ops(1, 2, 3, 4, 5, 6);
    set_job(2, 0, 0, 0, 0, -1); run_job();
    chk("err_cleared", err, 0);
    chk("err_job_data", last_data, 14);

    for (int n = 0; n < 25; n++) begin
      set_job($urandom_range(0, 6), 1'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, 3), -1);
      for (int i = 0; i < 8; i++) begin
        j_x[i] = $urandom; j_w[i] = $urandom; j_stall[i] = $urandom_range(0, 2);
      end
      if (j_k > 0 && $urandom_range(0, 5) == 0) j_abort_at = $urandom_range(0, j_k - 1);
      run_job();
    end

    // Asynchronous reset in the middle of a MAC stream.
    exp_lat = -1;
    @(negedge clk); #1;
    res_ready = 0; cfg_valid = 1; cfg_len = 5; cfg_bias_en = 0; cfg_relu_en = 0;
    @(negedge clk); #1; cfg_valid = 0; op_valid = 1; op_x = 9; op_w = 9;
    repeat (2) begin @(negedge clk); #1; end
    rst_n = 0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_idle", {cfg_ready, op_ready, pe_in_valid, res_valid}, 4'b1000);
    op_valid = 0;
    @(negedge clk); #1; rst_n = 1;
    fill_ops(7, 0, 0, 6, 0, 0);
    set_job(1, 0, 1, 0, 0, -1); run_job();
    chk("arst_next_data", last_data, 42);

    @(negedge clk); #1; res_ready = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Micro-op sequencer for one `pe` compute unit. It accepts a job descriptor (MAC length, bias and ReLU enables, bias value) and streams operand pairs into the PE with a valid/ready handshake. It issues the flush, MAC, bias, ReLU and output-enable micro-ops in a legal order, then returns the PE result on a valid/ready result port. It sits between the operand buffers and the PE. It never issues an illegal micro-op combination, and it monitors `illegal_uop` as a checker.

## Interface
- `LEN_W`, default 16: width of the MAC term count.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid` / `cfg_ready`  in / out  1 / 1  job handshake.
- `cfg_len`  in  LEN_W  number of MAC terms, 0 to 2^LEN_W-1.
- `cfg_bias_en`, `cfg_relu_en`  in  1 each  enable the bias step and the ReLU step.
- `cfg_bias`  in  XLEN  signed bias value.
- `op_valid` / `op_ready`  in / out  1 / 1  operand handshake.
- `op_x`, `op_w`  in  XLEN each  signed operands.
- `abort`  in  1  cancel the current job.
- `pe_x`, `pe_weight`  out  XLEN each  drive the PE `x` and `weight` inputs.
- `pe_in_valid`, `pe_flush`, `pe_out_en`, `pe_calc_bias`, `pe_calc_relu`  out  1 each  PE micro-op controls.
- `pe_result`  in  XLEN  PE `result_r`.
- `pe_out_valid`  in  1  PE `out_valid_r`.
- `pe_illegal_uop`  in  1  PE illegal micro-op flag.
- `res_valid` / `res_ready`  out / in  1 / 1  result handshake.
- `res_data`  out  XLEN  equals `pe_result`.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  sticky illegal-uop flag.

## Operation
- States: IDLE, FLUSH, MAC, BIAS, RELU, EMIT, OUT.
- IDLE
  - `cfg_ready`=1.
  - On `cfg_valid`: latch `cfg_len` into a down-counter, latch the enables and `cfg_bias`, clear `err`, go to FLUSH.
- FLUSH
  - `pe_flush`=1 for one cycle.
  - Next state: MAC if len≠0, else BIAS if bias_en, else RELU if relu_en, else EMIT.
- MAC
  - `op_ready`=1.
  - `pe_in_valid`=`op_valid`, `pe_x`=`op_x`, `pe_weight`=`op_w`.
  - Each handshake decrements the counter.
  - When `op_valid`=0 the micro-op is all-zero, so the PE holds.
  - After the handshake that brings the counter to 0, next state is BIAS, RELU or EMIT, using the same selection rule as FLUSH.
- BIAS
  - One cycle: `pe_in_valid`=1, `pe_calc_bias`=1, `pe_weight`=latched bias, `pe_x`=0.
  - Next state: RELU if relu_en, else EMIT.
- RELU: one cycle with `pe_calc_relu`=1 and `pe_in_valid`=0, then EMIT.
- EMIT: one cycle with only `pe_out_en`=1, then OUT.
- OUT
  - `res_valid`=`pe_out_valid`. The PE holds the result under the all-zero micro-op.
  - On `res_valid && res_ready`, go to IDLE.
- Outside MAC and BIAS, `pe_x` and `pe_weight` are driven to 0.
- Every PE control not listed for a state is 0.
- Arithmetic is performed entirely in the PE; accumulation wraps modulo 2^XLEN. The controller does no math beyond the counter.
- `abort`
  - In FLUSH, MAC, BIAS, RELU or EMIT: that cycle drives only `pe_flush`=1, `op_ready`=0, and the next state is IDLE. The partial result is discarded.
  - In IDLE or OUT: ignored.
- `err` is set in any cycle where `pe_illegal_uop`=1. It clears only on reset or on the next cfg accept.

## Timing
- Reset values:
  - state IDLE.
  - `cfg_ready`=1.
  - `op_ready`, `res_valid`, `busy`, `err` = 0.
  - All `pe_*` outputs = 0.
  - Counter and latched fields = 0.
- Example timeline with cfg accepted in cycle 0, K terms, no operand stalls, bias and ReLU enabled:
  - cycle 1: FLUSH.
  - cycles 2..K+1: MAC.
  - cycle K+2: BIAS.
  - cycle K+3: RELU.
  - cycle K+4: EMIT.
  - cycle K+5: `res_valid`=1.
- Each disabled step removes one cycle. Each operand stall adds one cycle.
- `res_data` and `res_valid` stay stable while `res_ready`=0.
- `cfg_ready`=0 from the accept cycle until the cycle after the result handshake.
- A new cfg can be accepted in the cycle after the handshake.
- `op_ready` is combinational from state only. It has no path from `op_valid`.
- `res_valid` is combinational from state and `pe_out_valid`.
- Asynchronous reset mid-job returns to the reset values immediately. Any in-flight operand or result is lost.

## Test plan
- Accumulate, bias, ReLU:
  - Stimulus: K=3, x={1,2,3}, w={4,5,6}, bias=-40, relu on.
  - Required: `res_data`=0, `res_valid` first high at cycle 8.
- Same job with relu off:
  - Required: `res_data`=0xFFFFFFF8 (-8 at XLEN=32), `res_valid` at cycle 7.
- Operand stalls:
  - Stimulus: same operands as the first test, `op_valid` low for 2 cycles between each operand.
  - Required: result unchanged, PE micro-op all-zero during the gaps, `res_valid` 4 cycles later than the no-stall case.
- Zero-length jobs:
  - len=0, bias=7, relu off: `res_data`=7.
  - len=0 with no steps: `res_data`=0, `res_valid` at cycle 3.
- Back-pressure:
  - Stimulus: `res_ready` held low for 5 cycles.
  - Required: `res_data` stable, `cfg_ready`=0; a second job is accepted the cycle after the handshake and computes correctly.
- Abort and error flag:
  - Abort during the 2nd MAC: one-cycle flush, then IDLE; the next job (K=1, 2×3) returns 6.
  - Forcing `pe_illegal_uop` high for one cycle sets `err` until the next cfg accept.
